// File: rtl/sap_clock_ctrl.sv
// SAP-1 CPU clock-enable generator: single-step, free-running at a selectable rate, and HLT stop.
// Consumes one-cycle debounced button pulses and issues a registered one-cycle clk_en.
`timescale 1ns/1ps

// state | meaning
// ------+----------------------------------------------------------
// STEP  | clk_en only on step_pulse; prescaler held at 0
// RUN   | prescaler free-runs, clk_en every (DIV_BASE >> speed) cycles
// HALT  | CPU executed HLT; no clk_en until clr is asserted
module sap_clock_ctrl #(
    parameter int DIV_BASE  = 3_000_000,
    parameter int DIV_WIDTH = 22
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       step_pulse,
    input  logic       mode_pulse,
    input  logic       hlt,
    input  logic [1:0] speed,
    output logic       clk_en,
    output logic       clk_led,
    output logic       run_mode,
    output logic       halted,
    output logic [7:0] tick_cnt
);

    typedef enum logic [1:0] {
        ST_STEP = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_BASE_W = DIV_WIDTH'(DIV_BASE);

    state_t               state;
    state_t               state_nxt;
    logic [DIV_WIDTH-1:0] prescaler;
    logic [DIV_WIDTH-1:0] prescaler_nxt;
    logic [DIV_WIDTH-1:0] run_period;
    logic [DIV_WIDTH-1:0] term_cnt;
    logic                 tick;

    // >= rather than == so a speed change to a shorter period still wraps promptly
    assign run_period = DIV_BASE_W >> speed;
    assign term_cnt   = run_period - DIV_WIDTH'(1);

    always_comb begin
        state_nxt     = state;
        prescaler_nxt = '0;
        tick          = 1'b0;
        unique case (state)
            ST_STEP: begin
                if (hlt) begin
                    state_nxt = ST_HALT;
                end else if (mode_pulse) begin
                    state_nxt = ST_RUN;
                end else if (step_pulse) begin
                    tick = 1'b1;
                end
            end
            ST_RUN: begin
                if (hlt) begin
                    state_nxt = ST_HALT;
                end else if (mode_pulse) begin
                    state_nxt = ST_STEP;
                end else if (prescaler >= term_cnt) begin
                    tick = 1'b1;
                end else begin
                    prescaler_nxt = prescaler + DIV_WIDTH'(1);
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_STEP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= ST_STEP;
            prescaler <= '0;
            clk_en    <= 1'b0;
            clk_led   <= 1'b0;
            run_mode  <= 1'b0;
            halted    <= 1'b0;
            tick_cnt  <= 8'd0;
        end else begin
            state     <= state_nxt;
            prescaler <= prescaler_nxt;
            clk_en    <= tick;
            run_mode  <= (state_nxt == ST_RUN);
            halted    <= (state_nxt == ST_HALT);
            if (tick) begin
                clk_led  <= ~clk_led;
                tick_cnt <= tick_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sap_clock_ctrl.sv
// Scoreboard bench for sap_clock_ctrl: stimulus pushes expected clk_en events (cycle, tick_cnt, clk_led),
// a negedge monitor pops and compares each clk_en the DUT produces.
`timescale 1ns/1ps

module tb_sap_clock_ctrl;

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
        logic       led;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr;
    logic       step_pulse;
    logic       mode_pulse;
    logic       hlt;
    logic [1:0] speed;
    logic       clk_en;
    logic       clk_led;
    logic       run_mode;
    logic       halted;
    logic [7:0] tick_cnt;

    int         cyc_num = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_ticks = 8'd0;
    exp_t       sb[$];

    sap_clock_ctrl #(.DIV_BASE(16), .DIV_WIDTH(5)) dut (
        .clk(clk), .clr(clr), .step_pulse(step_pulse), .mode_pulse(mode_pulse),
        .hlt(hlt), .speed(speed), .clk_en(clk_en), .clk_led(clk_led),
        .run_mode(run_mode), .halted(halted), .tick_cnt(tick_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_num <= cyc_num + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // monitor: every clk_en must match the oldest expected event
    always @(negedge clk) begin
        if (clk_en === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL clk_en_unexpected: got clk_en at cycle %0d required none", cyc_num);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.cyc != cyc_num || e.cnt !== tick_cnt || e.led !== clk_led) begin
                    n_err++;
                    $display("FAIL clk_en_event: got cyc=%0d cnt=%0d led=%0b required cyc=%0d cnt=%0d led=%0b",
                             cyc_num, tick_cnt, clk_led, e.cyc, e.cnt, e.led);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc_num < target) tick();
    endtask

    function automatic void expect_at(input int at);
        exp_t e;
        exp_ticks = exp_ticks + 8'd1;
        e.cyc = at;
        e.cnt = exp_ticks;
        e.led = exp_ticks[0];
        sb.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic step_once();
        expect_at(cyc_num + 1);
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        tick();
        clr = 1'b1;
        exp_ticks = 8'd0;
    endtask

    initial begin
        int c;
        int d;
        int e;
        int f;
        clr = 1'b0; step_pulse = 1'b0; mode_pulse = 1'b0; hlt = 1'b0; speed = 2'd0;
        repeat (3) tick();
        check("rst_clk_en", 32'(clk_en), 0);
        check("rst_clk_led", 32'(clk_led), 0);
        check("rst_run_mode", 32'(run_mode), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_tick_cnt", 32'(tick_cnt), 0);
        clr = 1'b1;
        tick();

        // three single steps, 10 cycles apart
        for (int i = 0; i < 3; i++) begin
            step_once();
            repeat (9) tick();
        end
        check("step_tick_cnt", 32'(tick_cnt), 3);
        check("step_clk_led", 32'(clk_led), 1);
        check("step_run_mode", 32'(run_mode), 0);

        // RUN at speed 0, then speed 2; step ignored
        c = cyc_num;
        expect_at(c + 17);
        expect_at(c + 33);
        expect_at(c + 49);
        mode_pulse = 1'b1;
        tick();
        mode_pulse = 1'b0;
        tick();
        check("run_entry_run_mode", 32'(run_mode), 1);
        wait_until(c + 49);
        speed = 2'd2;
        expect_at(c + 53);
        expect_at(c + 57);
        expect_at(c + 61);
        wait_until(c + 54);
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        // mode_pulse lands on the terminal count at c+65: no tick
        wait_until(c + 64);
        mode_pulse = 1'b1;
        tick();
        mode_pulse = 1'b0;
        tick();
        check("mode_tc_run_mode", 32'(run_mode), 0);
        repeat (10) tick();

        // re-enter RUN: prescaler restarts from 0; hlt on a terminal count suppresses it
        d = cyc_num;
        expect_at(d + 5);
        expect_at(d + 9);
        mode_pulse = 1'b1;
        tick();
        mode_pulse = 1'b0;
        wait_until(d + 12);
        hlt = 1'b1;
        tick();
        hlt = 1'b0;
        tick();
        check("halt_halted", 32'(halted), 1);
        check("halt_run_mode", 32'(run_mode), 0);
        for (int i = 0; i < 100; i++) begin
            step_pulse = (i % 10 == 3);
            mode_pulse = (i % 10 == 7);
            hlt        = (i % 20 == 11);
            tick();
        end
        step_pulse = 1'b0; mode_pulse = 1'b0; hlt = 1'b0;
        check("halt_hold_halted", 32'(halted), 1);
        check("halt_hold_tick_cnt", 32'(tick_cnt), 11);
        do_reset();
        check("halt_clr_halted", 32'(halted), 0);
        check("halt_clr_run_mode", 32'(run_mode), 0);
        check("halt_clr_clk_led", 32'(clk_led), 0);
        check("halt_clr_tick_cnt", 32'(tick_cnt), 0);
        check("halt_clr_clk_en", 32'(clk_en), 0);

        // 256 steps wrap tick_cnt
        for (int i = 0; i < 256; i++) begin
            step_once();
            tick();
        end
        tick();
        check("wrap_tick_cnt", 32'(tick_cnt), 0);
        check("wrap_clk_led", 32'(clk_led), 0);

        // step + mode together: mode wins; then clr mid-RUN at prescaler 7
        speed = 2'd0;
        e = cyc_num;
        step_pulse = 1'b1;
        mode_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        mode_pulse = 1'b0;
        tick();
        check("both_run_mode", 32'(run_mode), 1);
        wait_until(e + 8);
        do_reset();
        check("midrun_clr_run_mode", 32'(run_mode), 0);
        check("midrun_clr_clk_en", 32'(clk_en), 0);
        check("midrun_clr_tick_cnt", 32'(tick_cnt), 0);

        // speed 3 (period 2) from a cleared prescaler; mode_pulse suppresses the tick due at f+7
        speed = 2'd3;
        f = cyc_num;
        expect_at(f + 3);
        expect_at(f + 5);
        mode_pulse = 1'b1;
        tick();
        mode_pulse = 1'b0;
        wait_until(f + 6);
        mode_pulse = 1'b1;
        tick();
        mode_pulse = 1'b0;
        repeat (6) tick();
        check("fast_run_mode", 32'(run_mode), 0);
        check("fast_tick_cnt", 32'(tick_cnt), 2);
        check("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
